tank_model: RTL and testbench

TANK_MODEL -- requirements
Module: tank_model

---
 rtl/tank_model_pkg.sv | 15 +
 rtl/tank_model_if.sv | 23 ++
 rtl/tank_model_tick_gen.sv | 26 ++
 rtl/tank_model.sv | 132 +++++++++++++
 tb/tb_tank_model.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/tank_model_pkg.sv
// Shared types and constants for the tank plant model.
// State encoding, hysteresis band and fault bit positions.
package tank_model_pkg;

    typedef enum logic [1:0] {
        LOW  = 2'd0,
        MID  = 2'd1,
        HIGH = 2'd2
    } tankState_t;

    localparam int HYST      = 8;
    localparam int FAULT_OVF = 1;
    localparam int FAULT_DRY = 0;

endpackage

// File: rtl/tank_model_if.sv
// Plant-side signal bundle between the tank and its pump controller.
// master = controller side, slave = tank side.
interface tank_model_if #(
    parameter int LEVEL_W = 8
);
    logic               inflow;
    logic               b0;
    logic               b1;
    logic [LEVEL_W-1:0] level;
    logic               out_i;
    logic               out_s;
    logic [1:0]         fault;

    modport master (
        output inflow, b0, b1,
        input  level, out_i, out_s, fault
    );

    modport slave (
        input  inflow, b0, b1,
        output level, out_i, out_s, fault
    );
endinterface

// File: rtl/tank_model_tick_gen.sv
// Level-update prescaler: counts 0..TICK_DIV-1, tick marks the wrap cycle.
// First tick edge lands TICK_DIV clocks after reset release.
module tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rstN,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);
endmodule

// File: rtl/tank_model.sv
// Water tank plant: saturating level integrator with LOW/MID/HIGH hysteresis FSM.
// Optional sticky overflow/dry-run flags when TANK_FAULT_EN is defined.
module tank_model
    import tank_model_pkg::*;
#(
    parameter int LEVEL_W   = 8,
    parameter int HI_TH     = 200,
    parameter int LO_TH     = 40,
    parameter int TICK_DIV  = 4,
    parameter int IN_RATE   = 1,
    parameter int PUMP_RATE = 2
) (
    input  logic clk,
    input  logic reset,
    tank_model_if.slave tank
);
    localparam int SW = LEVEL_W + 3;

    localparam logic signed [SW-1:0] MAXV = $signed({3'b000, {LEVEL_W{1'b1}}});
    localparam logic signed [SW-1:0] INC  = SW'(IN_RATE);
    localparam logic signed [SW-1:0] DEC  = SW'(PUMP_RATE);

    localparam logic [LEVEL_W-1:0] LO_L   = LEVEL_W'(LO_TH);
    localparam logic [LEVEL_W-1:0] HI_L   = LEVEL_W'(HI_TH);
    localparam logic [LEVEL_W-1:0] LO_HYS = LEVEL_W'(LO_TH + HYST);
    localparam logic [LEVEL_W-1:0] HI_HYS = LEVEL_W'(HI_TH - HYST);

    logic                tick;
    logic signed [SW-1:0] sum;
    logic [LEVEL_W-1:0]  levelNext;
    logic [LEVEL_W-1:0]  levelQ;
    tankState_t          state;
    logic                outI;
    logic                outS;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) uTick (
        .clk  (clk),
        .rstN (reset),
        .tick (tick)
    );

    // Net flow is summed in a widened signed domain, then clamped.
    always_comb begin
        sum = $signed({3'b000, levelQ});
        if (tank.inflow) sum = sum + INC;
        if (tank.b0)     sum = sum - DEC;
        if (tank.b1)     sum = sum - DEC;
        if (sum < 0) begin
            levelNext = '0;
        end else if (sum > MAXV) begin
            levelNext = '1;
        end else begin
            levelNext = sum[LEVEL_W-1:0];
        end
    end

    // FSM judges the level being written this tick, so flags move with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            levelQ <= LO_L;
            state  <= LOW;
            outI   <= 1'b0;
            outS   <= 1'b1;
        end else if (tick) begin
            levelQ <= levelNext;
            unique case (state)
                LOW: begin
                    if (levelNext >= HI_L) begin
                        state <= HIGH;
                        outI  <= 1'b1;
                        outS  <= 1'b0;
                    end else if (levelNext > LO_HYS) begin
                        state <= MID;
                        outS  <= 1'b0;
                    end
                end
                MID: begin
                    if (levelNext >= HI_L) begin
                        state <= HIGH;
                        outI  <= 1'b1;
                    end else if (levelNext <= LO_L) begin
                        state <= LOW;
                        outS  <= 1'b1;
                    end
                end
                HIGH: begin
                    if (levelNext <= LO_L) begin
                        state <= LOW;
                        outI  <= 1'b0;
                        outS  <= 1'b1;
                    end else if (levelNext < HI_HYS) begin
                        state <= MID;
                        outI  <= 1'b0;
                    end
                end
                default: begin
                    state <= LOW;
                    outI  <= 1'b0;
                    outS  <= 1'b1;
                end
            endcase
        end
    end

    assign tank.level = levelQ;
    assign tank.out_i = outI;
    assign tank.out_s = outS;

`ifdef TANK_FAULT_EN
    logic [1:0] faultQ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            faultQ <= 2'b00;
        end else if (tick) begin
            if (tank.inflow && (sum > MAXV)) begin
                faultQ[FAULT_OVF] <= 1'b1;
            end
            if ((tank.b0 || tank.b1) && (levelQ == '0)) begin
                faultQ[FAULT_DRY] <= 1'b1;
            end
        end
    end

    assign tank.fault = faultQ;
`else
    assign tank.fault = 2'b00;
`endif

endmodule

// File: tb/tb_tank_model.sv
// Self-checking bench for tank_model: reference model feeds a scoreboard queue.
// Honors TANK_FAULT_EN for fault expectations.
module tb_tank_model;

    typedef struct {
        int level;
        int outI;
        int outS;
        int fault;
    } exp_t;

    logic clk = 1'b0;
    logic rstN;

    int nTests = 0;
    int nFail  = 0;

    exp_t sbQ[$];

    int mCnt   = 0;
    int mLevel = 40;
    int mState = 0;
    int mFault = 0;

    tank_model_if #(.LEVEL_W(8)) tif ();

    tank_model dut (
        .clk   (clk),
        .reset (rstN),
        .tank  (tif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        nTests++;
        if (obs != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference plant: level update on every 4th clock after reset.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mCnt   = 0;
            mLevel = 40;
            mState = 0;
            mFault = 0;
            sbQ.delete();
        end else if (mCnt == 3) begin
            int nx;
            exp_t e;
            mCnt = 0;
            nx = mLevel + (tif.inflow ? 1 : 0)
                 - (tif.b0 ? 2 : 0) - (tif.b1 ? 2 : 0);
`ifdef TANK_FAULT_EN
            if (tif.inflow && nx > 255) mFault = mFault | 2;
            if ((tif.b0 || tif.b1) && mLevel == 0) mFault = mFault | 1;
`endif
            if (nx < 0) nx = 0;
            if (nx > 255) nx = 255;
            mLevel = nx;
            case (mState)
                0: if (nx >= 200) mState = 2; else if (nx > 48) mState = 1;
                1: if (nx >= 200) mState = 2; else if (nx <= 40) mState = 0;
                default: if (nx <= 40) mState = 0; else if (nx < 192) mState = 1;
            endcase
            e.level = mLevel;
            e.outI  = (mState == 2) ? 1 : 0;
            e.outS  = (mState == 0) ? 1 : 0;
            e.fault = mFault;
            sbQ.push_back(e);
        end else begin
            mCnt = mCnt + 1;
        end
    end

    always @(negedge clk) begin
        if (rstN) begin
            while (sbQ.size() > 0) begin
                exp_t e;
                e = sbQ.pop_front();
                chk("sbLevel", int'(tif.level), e.level);
                chk("sbOutI", int'(tif.out_i), e.outI);
                chk("sbOutS", int'(tif.out_s), e.outS);
                chk("sbFault", int'(tif.fault), e.fault);
            end
        end
    end

    task automatic waitLevel(input int tgt);
        int n;
        n = 0;
        while (int'(tif.level) != tgt && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("waitLevel", int'(tif.level), tgt);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
    endtask

    initial begin
        int k;
        rstN       = 1'b0;
        tif.inflow = 1'b0;
        tif.b0     = 1'b0;
        tif.b1     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstLevel", int'(tif.level), 40);
        chk("rstOutS", int'(tif.out_s), 1);
        chk("rstOutI", int'(tif.out_i), 0);
        chk("rstFault", int'(tif.fault), 0);
        rstN = 1'b1;

        repeat (100) @(negedge clk);
        chk("idleLevel", int'(tif.level), 40);

        tif.inflow = 1'b1;
        waitLevel(48);
        chk("outS@48", int'(tif.out_s), 1);
        waitLevel(49);
        chk("outS@49", int'(tif.out_s), 0);
        waitLevel(199);
        chk("outI@199", int'(tif.out_i), 0);
        waitLevel(200);
        chk("outI@200", int'(tif.out_i), 1);

        tif.inflow = 1'b0;
        tif.b0     = 1'b1;
        waitLevel(192);
        chk("outI@192", int'(tif.out_i), 1);
        waitLevel(190);
        chk("outI@190", int'(tif.out_i), 0);

        tif.inflow = 1'b1;
        tif.b1     = 1'b1;
        repeat (12) @(negedge clk);
        chk("netSum", int'(tif.level), 181);

        tif.b0 = 1'b0;
        tif.b1 = 1'b0;
        waitLevel(255);
        repeat (8) @(negedge clk);
        chk("satMax", int'(tif.level), 255);
`ifdef TANK_FAULT_EN
        chk("faultOvf", int'(tif.fault), 2);
`else
        chk("faultOvf", int'(tif.fault), 0);
`endif

        pulseReset();
        chk("faultClr", int'(tif.fault), 0);
        tif.inflow = 1'b0;
        tif.b0     = 1'b1;
        tif.b1     = 1'b1;
        waitLevel(0);
        repeat (12) @(negedge clk);
        chk("satMin", int'(tif.level), 0);
`ifdef TANK_FAULT_EN
        chk("faultDry", int'(tif.fault), 1);
`else
        chk("faultDry", int'(tif.fault), 0);
`endif

        pulseReset();
        tif.inflow = 1'b1;
        tif.b0     = 1'b0;
        tif.b1     = 1'b0;
        waitLevel(120);
        repeat (2) @(negedge clk);
        rstN = 1'b0;
        #1;
        chk("midRstLevel", int'(tif.level), 40);
        chk("midRstOutS", int'(tif.out_s), 1);
        chk("midRstOutI", int'(tif.out_i), 0);
        @(negedge clk);
        rstN = 1'b1;
        k = 0;
        while (int'(tif.level) == 40 && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("firstUpd", k, 4);
        chk("firstUpdLvl", int'(tif.level), 41);

        repeat (10) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
